// File: rtl/cnn_pkg.sv
// Shared constants and state encoding for the CNN inference datapath.
package cnn_pkg;

    localparam int unsigned L1_CHANNELS = 16;
    localparam int unsigned L1_CONV_DIM = 26;
    localparam int unsigned L1_POOL_DIM = 13;
    localparam int unsigned BUF_A_AW    = 14;
    localparam int unsigned BUF_B_AW    = 12;

    // Max-pool engine states: four window reads, then a one-cycle finish.
    typedef enum logic [2:0] {
        StIdle,
        StRd0,
        StRd1,
        StRd2,
        StRd3,
        StFin
    } pool_state_e;

endpackage

// File: rtl/max_u8.sv
// Combinational unsigned maximum of two bytes.
module max_u8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] y
);

    // Pick the larger operand.
    always_comb begin
        y = (a > b) ? a : b;
    end

endmodule

// File: rtl/maxpool2x2_l1.sv
// Layer-1 2x2 / stride-2 max-pool engine: reads buf_a (CHANNELS x IN_DIM x IN_DIM)
// once per location and writes CHANNELS x OUT_DIM x OUT_DIM maxima to buf_b.
// Optional macro MAXPOOL_CYCLE_COUNT_EN adds a cycle_count output.
module maxpool2x2_l1
    import cnn_pkg::*;
#(
    parameter int unsigned CHANNELS = L1_CHANNELS,
    parameter int unsigned IN_DIM   = L1_CONV_DIM,
    parameter int unsigned A_AW     = BUF_A_AW,
    parameter int unsigned B_AW     = BUF_B_AW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic [A_AW-1:0] buf_a_addr,
    input  logic [7:0]      buf_a_rd_data,
    output logic [B_AW-1:0] buf_b_addr,
    output logic [7:0]      buf_b_wr_data,
    output logic            buf_b_wr_en
`ifdef MAXPOOL_CYCLE_COUNT_EN
    ,
    output logic [15:0]     cycle_count
`endif
);

    localparam int unsigned OUT_DIM = IN_DIM / 2;

    localparam logic [A_AW-1:0] A_ONE      = A_AW'(1);
    localparam logic [A_AW-1:0] A_COL_STEP = A_AW'(2);
    localparam logic [A_AW-1:0] A_ROW      = A_AW'(IN_DIM);
    localparam logic [A_AW-1:0] A_ROW_STEP = A_AW'(2 * IN_DIM);
    localparam logic [B_AW-1:0] B_ONE      = B_AW'(1);
    localparam logic [15:0]     LAST_POS   = 16'(OUT_DIM - 1);
    localparam logic [15:0]     LAST_CH    = 16'(CHANNELS - 1);

    pool_state_e     state_q, state_d;
    logic [15:0]     ch_q, ch_d;
    logic [15:0]     r_q, r_d;
    logic [15:0]     c_q, c_d;
    // base_q: top-left of the current window; row_base_q: start of the current row pair.
    logic [A_AW-1:0] base_q, base_d;
    logic [A_AW-1:0] row_base_q, row_base_d;
    logic [B_AW-1:0] o_q, o_d;
    logic [7:0]      max_q, max_d;
    logic [7:0]      max_out;
    logic            last_out;

    max_u8 u_max (
        .a (max_q),
        .b (buf_a_rd_data),
        .y (max_out)
    );

    assign last_out = (ch_q == LAST_CH) && (r_q == LAST_POS) && (c_q == LAST_POS);

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            ch_q       <= '0;
            r_q        <= '0;
            c_q        <= '0;
            base_q     <= '0;
            row_base_q <= '0;
            o_q        <= '0;
            max_q      <= '0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            r_q        <= r_d;
            c_q        <= c_d;
            base_q     <= base_d;
            row_base_q <= row_base_d;
            o_q        <= o_d;
            max_q      <= max_d;
        end
    end

    // Next-state, window walk and running-max update.
    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        r_d        = r_q;
        c_d        = c_q;
        base_d     = base_q;
        row_base_d = row_base_q;
        o_d        = o_q;
        max_d      = max_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d    = StRd0;
                    ch_d       = '0;
                    r_d        = '0;
                    c_d        = '0;
                    base_d     = '0;
                    row_base_d = '0;
                    o_d        = '0;
                end
            end
            StRd0: begin
                max_d   = buf_a_rd_data;
                state_d = StRd1;
            end
            StRd1: begin
                max_d   = max_out;
                state_d = StRd2;
            end
            StRd2: begin
                max_d   = max_out;
                state_d = StRd3;
            end
            StRd3: begin
                o_d = o_q + B_ONE;
                if (c_q == LAST_POS) begin
                    c_d = '0;
                    // Next row pair; after the last row pair this lands on the next channel.
                    row_base_d = row_base_q + A_ROW_STEP;
                    base_d     = row_base_q + A_ROW_STEP;
                    if (r_q == LAST_POS) begin
                        r_d  = '0;
                        ch_d = ch_q + 16'd1;
                    end else begin
                        r_d = r_q + 16'd1;
                    end
                end else begin
                    c_d    = c_q + 16'd1;
                    base_d = base_q + A_COL_STEP;
                end
                state_d = last_out ? StFin : StRd0;
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs decoded from the current state.
    always_comb begin
        busy          = 1'b0;
        done          = 1'b0;
        buf_a_addr    = '0;
        buf_b_addr    = '0;
        buf_b_wr_data = '0;
        buf_b_wr_en   = 1'b0;
        case (state_q)
            StRd0: begin
                busy       = 1'b1;
                buf_a_addr = base_q;
                buf_b_addr = o_q;
            end
            StRd1: begin
                busy       = 1'b1;
                buf_a_addr = base_q + A_ONE;
                buf_b_addr = o_q;
            end
            StRd2: begin
                busy       = 1'b1;
                buf_a_addr = base_q + A_ROW;
                buf_b_addr = o_q;
            end
            StRd3: begin
                busy          = 1'b1;
                buf_a_addr    = base_q + A_ROW + A_ONE;
                buf_b_addr    = o_q;
                buf_b_wr_data = max_out;
                buf_b_wr_en   = 1'b1;
            end
            StFin: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

`ifdef MAXPOOL_CYCLE_COUNT_EN
    logic [15:0] cycle_count_q;

    // Pass-length counter: clears on an accepted start, counts busy cycles, then holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_count_q <= '0;
        end else if ((state_q == StIdle) && start) begin
            cycle_count_q <= '0;
        end else if (busy) begin
            cycle_count_q <= cycle_count_q + 16'd1;
        end
    end

    assign cycle_count = cycle_count_q;
`endif

endmodule

// File: tb/tb_maxpool2x2_l1.sv
// Directed bench for maxpool2x2_l1 with behavioural buf_a/buf_b memories.
// Define MAXPOOL_CYCLE_COUNT_EN to also check the cycle_count port.
module tb_maxpool2x2_l1;

    localparam int A_N = 10816;
    localparam int B_N = 2704;
    localparam int IN  = 26;
    localparam int OD  = 13;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic [13:0] buf_a_addr;
    logic [7:0]  buf_a_rd_data;
    logic [11:0] buf_b_addr;
    logic [7:0]  buf_b_wr_data;
    logic        buf_b_wr_en;
`ifdef MAXPOOL_CYCLE_COUNT_EN
    logic [15:0] cycle_count;
`endif

    logic [7:0] mem_a [A_N];
    logic [7:0] mem_b [B_N];
    bit         written [B_N];

    int n_cmp = 0;
    int n_bad = 0;

    int pe = 0;
    int t0 = 0;
    bit mon_clr = 1'b0;
    int wr_cnt, dup_cnt, done_cnt, last_wr_cyc, done_cyc;
    int h [4];
    int win168 [4];
    int win169 [4];

    maxpool2x2_l1 dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .buf_a_addr    (buf_a_addr),
        .buf_a_rd_data (buf_a_rd_data),
        .buf_b_addr    (buf_b_addr),
        .buf_b_wr_data (buf_b_wr_data),
        .buf_b_wr_en   (buf_b_wr_en)
`ifdef MAXPOOL_CYCLE_COUNT_EN
        ,
        .cycle_count   (cycle_count)
`endif
    );

    always #5 clk = ~clk;

    assign buf_a_rd_data = (int'(buf_a_addr) < A_N) ? mem_a[buf_a_addr] : 8'h00;

    always @(posedge clk) pe <= pe + 1;

    // Write monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (mon_clr) begin
            wr_cnt = 0; dup_cnt = 0; done_cnt = 0; last_wr_cyc = -1; done_cyc = -1;
            for (int i = 0; i < B_N; i++) begin
                mem_b[i]   = 8'hxx;
                written[i] = 1'b0;
            end
            for (int i = 0; i < 4; i++) begin
                h[i] = -1; win168[i] = -1; win169[i] = -1;
            end
        end else begin
            h[0] = h[1]; h[1] = h[2]; h[2] = h[3]; h[3] = int'(buf_a_addr);
            if (buf_b_wr_en === 1'b1) begin
                wr_cnt++;
                last_wr_cyc = pe - t0;
                if (int'(buf_b_addr) < B_N) begin
                    if (written[buf_b_addr]) dup_cnt++;
                    written[buf_b_addr] = 1'b1;
                    mem_b[buf_b_addr]   = buf_b_wr_data;
                end
                if (buf_b_addr == 12'd168) win168 = h;
                if (buf_b_addr == 12'd169) win169 = h;
            end
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = pe - t0;
            end
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic mon_clear();
        @(posedge clk);
        mon_clr = 1'b1;
        @(posedge clk);
        mon_clr = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        t0    = pe;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (done_cnt != 0) break;
        end
        repeat (3) @(negedge clk);
    endtask

    function automatic int ref_out(input int o);
        int ch, r, c, b, m;
        ch = o / (OD * OD);
        r  = (o % (OD * OD)) / OD;
        c  = o % OD;
        b  = ch * IN * IN + 2 * r * IN + 2 * c;
        m  = int'(mem_a[b]);
        if (int'(mem_a[b + 1]) > m)      m = int'(mem_a[b + 1]);
        if (int'(mem_a[b + IN]) > m)     m = int'(mem_a[b + IN]);
        if (int'(mem_a[b + IN + 1]) > m) m = int'(mem_a[b + IN + 1]);
        return m;
    endfunction

    function automatic int ref_bad();
        int bad = 0;
        for (int o = 0; o < B_N; o++) begin
            if (!written[o] || (int'(mem_b[o]) != ref_out(o))) bad++;
        end
        return bad;
    endfunction

    initial begin
        int k_cnt;
        int x_wr, x_busy, x_done;
        int off [4];
        off[0] = 0; off[1] = 1; off[2] = IN; off[3] = IN + 1;

        rst   = 1'b1;
        start = 1'b0;
        for (int i = 0; i < A_N; i++) mem_a[i] = 8'(i % 128);
        repeat (3) @(negedge clk);

        // Reset state.
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_wr_en", int'(buf_b_wr_en), 0);
        check("rst_a_addr", int'(buf_a_addr), 0);
        check("rst_b_addr", int'(buf_b_addr), 0);
        check("rst_wr_data", int'(buf_b_wr_data), 0);
`ifdef MAXPOOL_CYCLE_COUNT_EN
        check("rst_cycle_count", int'(cycle_count), 0);
`endif
        rst = 1'b0;

        // Ramp pattern i%128, full pass against the reference.
        mon_clear();
        pulse_start();
        check("ramp_busy_c1", int'(busy), 1);
        wait_done(11000);
        check("ramp_done_cnt", done_cnt, 1);
        check("ramp_done_cyc", done_cyc, 10817);
        check("ramp_last_wr_cyc", last_wr_cyc, 10816);
        check("ramp_wr_cnt", wr_cnt, B_N);
        check("ramp_dups", dup_cnt, 0);
        check("ramp_ref_bad", ref_bad(), 0);
        check("ramp_b0", int'(mem_b[0]), 27);
        check("ramp_b1", int'(mem_b[1]), 29);
        check("ramp_idle_busy", int'(busy), 0);
        check("win168_0", win168[0], 648);
        check("win168_1", win168[1], 649);
        check("win168_2", win168[2], 674);
        check("win168_3", win168[3], 675);
        check("win169_0", win169[0], 676);
        check("win169_1", win169[1], 677);
        check("win169_2", win169[2], 702);
        check("win169_3", win169[3], 703);
`ifdef MAXPOOL_CYCLE_COUNT_EN
        check("cc_after_done", int'(cycle_count), 10816);
`endif

        // Directed windows on a zero background; max moved through each position.
        for (int i = 0; i < A_N; i++) mem_a[i] = 8'd0;
        mem_a[0] = 8'd5; mem_a[1] = 8'd9; mem_a[IN] = 8'd3; mem_a[IN + 1] = 8'd7;
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 4; j++) mem_a[2 + 2 * k + off[j]] = 8'(20 + k);
            mem_a[2 + 2 * k + off[k]] = 8'(100 + k);
        end
        mon_clear();
        pulse_start();
`ifdef MAXPOOL_CYCLE_COUNT_EN
        check("cc_cleared", int'(cycle_count), 0);
`endif
        wait_done(11000);
        check("win_b0", int'(mem_b[0]), 9);
        check("win_pos0", int'(mem_b[1]), 100);
        check("win_pos1", int'(mem_b[2]), 101);
        check("win_pos2", int'(mem_b[3]), 102);
        check("win_pos3", int'(mem_b[4]), 103);
        k_cnt = 0;
        for (int o = 5; o < B_N; o++) if (!written[o] || mem_b[o] != 8'd0) k_cnt++;
        check("zero_rest_bad", k_cnt, 0);
        check("zero_wr_cnt", wr_cnt, B_N);
        check("zero_dups", dup_cnt, 0);

        // All-127 buffer.
        for (int i = 0; i < A_N; i++) mem_a[i] = 8'd127;
        mon_clear();
        pulse_start();
        wait_done(11000);
        k_cnt = 0;
        for (int o = 0; o < B_N; o++) if (!written[o] || mem_b[o] != 8'd127) k_cnt++;
        check("sat_bad", k_cnt, 0);
        check("sat_wr_cnt", wr_cnt, B_N);
        check("sat_dups", dup_cnt, 0);

        // Stray start pulses mid-pass and on the FIN cycle.
        for (int i = 0; i < A_N; i++) mem_a[i] = 8'(i % 128);
        mon_clear();
        pulse_start();
        k_cnt = 0;
        for (int i = 0; i < 11000; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (pe - t0 == 500) start = 1'b1;
            if (done === 1'b1) begin
                start = 1'b1;
                k_cnt = 1;
                break;
            end
        end
        @(negedge clk);
        start  = 1'b0;
        x_busy = int'(busy);
        repeat (4) begin
            @(negedge clk);
            x_busy += int'(busy);
        end
        check("fin_seen", k_cnt, 1);
        check("fin_start_ignored", x_busy, 0);
        check("stray_done_cyc", done_cyc, 10817);
        check("stray_done_cnt", done_cnt, 1);
        check("stray_wr_cnt", wr_cnt, B_N);
        check("stray_ref_bad", ref_bad(), 0);

        // Reset mid-pass at cycle 3000.
        mon_clear();
        pulse_start();
        for (int i = 0; i < 3100; i++) begin
            @(negedge clk);
            if (pe - t0 == 3000) break;
        end
        rst = 1'b1;
        @(negedge clk);
        rst    = 1'b0;
        x_wr   = int'(buf_b_wr_en);
        x_busy = int'(busy);
        x_done = int'(done);
`ifdef MAXPOOL_CYCLE_COUNT_EN
        check("cc_after_rst", int'(cycle_count), 0);
`endif
        repeat (40) begin
            @(negedge clk);
            x_wr   += int'(buf_b_wr_en);
            x_busy += int'(busy);
            x_done += int'(done);
        end
        check("abort_wr_en", x_wr, 0);
        check("abort_busy", x_busy, 0);
        check("abort_done", x_done, 0);
        check("abort_wr_cnt", wr_cnt, 750);

        // Fresh pass after the abort.
        mon_clear();
        pulse_start();
        wait_done(11000);
        check("rerun_done_cyc", done_cyc, 10817);
        check("rerun_wr_cnt", wr_cnt, B_N);
        check("rerun_ref_bad", ref_bad(), 0);
`ifdef MAXPOOL_CYCLE_COUNT_EN
        check("rerun_cc", int'(cycle_count), 10816);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
